// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game-of-Life cell matrix and its readers.
//   DEF_ROWS / DEF_COLS : default grid geometry
//   state_t             : scanner FSM states; idx() : row-major bit index of grid[r][c]
package life_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  typedef enum logic {IDLE, SEND} state_t;

  // Bit position of cell (r,c) in a flattened grid. The cell matrix uses the
  // same helper, so writer and reader cannot disagree on bit order.
  function automatic int idx(input int r, input int c, input int cols = DEF_COLS);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_popcount.sv
// life_popcount: purely combinational count of set bits in a flattened grid.
//   bits  : N input bits
//   count : number of ones, width $clog2(N+1); the caller registers it
module life_popcount #(
  parameter int N = 64,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  // Written as a linear sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/life_grid_scanner.sv
// life_grid_scanner: snapshots the grid on each accepted gen_tick and streams it
//   out one row per beat (valid/ready), with generation number and live count.
//   Ports: clk/_rst, grid_flat, gen_tick, out_ready in; out_valid/out_row/
//   out_row_idx/out_sof/out_eof, gen_count, live_count, busy, overrun, ovr_count out.
module life_grid_scanner
  import life_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int GEN_W = 16,
  parameter int OVR_W = 8,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(ROWS * COLS + 1)
) (
  input  logic                 clk,
  input  logic                 _rst,
  input  logic [ROWS*COLS-1:0] grid_flat,
  input  logic                 gen_tick,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [COLS-1:0]      out_row,
  output logic [RW-1:0]        out_row_idx,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [GEN_W-1:0]     gen_count,
  output logic [CW-1:0]        live_count,
  output logic                 busy,
  output logic                 overrun,
  output logic [OVR_W-1:0]     ovr_count
);

  state_t                 state, state_nxt;
  logic [ROWS*COLS-1:0]   snap;
  logic [RW-1:0]          row_ptr;
  logic [CW-1:0]          pop;
  logic                   send, hs, last, accept, drop;

  life_popcount #(.N(ROWS * COLS), .W(CW)) u_popcount (
    .bits  (grid_flat),
    .count (pop)
  );

  assign send = (state == SEND);
  assign hs   = send && out_ready;
  assign last = (row_ptr == RW'(ROWS - 1));

  // A tick is taken when idle, or when it lands on the final handshake so the
  // next frame follows with no bubble. Any other tick during SEND is dropped.
  assign accept = gen_tick && (!send || (hs && last));
  assign drop   = gen_tick && send && !(hs && last);

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (gen_tick) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (hs && last && !gen_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rows are muxed out of the snapshot by pointer, so a stalled beat holds
  // without any extra storage.
  assign out_row     = snap[idx(int'(row_ptr), 0, COLS) +: COLS];
  assign out_row_idx = row_ptr;
  assign out_sof     = send && (row_ptr == '0);
  assign out_eof     = send && last;

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      snap       <= '0;
      row_ptr    <= '0;
      gen_count  <= '0;
      live_count <= '0;
      overrun    <= 1'b0;
      ovr_count  <= '0;
    end else begin
      if (accept) begin
        snap       <= grid_flat;
        gen_count  <= gen_count + GEN_W'(1);
        live_count <= pop;
        row_ptr    <= '0;
      end else if (hs) begin
        row_ptr <= last ? '0 : row_ptr + RW'(1);
      end
      if (drop) begin
        overrun <= 1'b1;
        if (ovr_count != '1) ovr_count <= ovr_count + OVR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_life_grid_scanner.sv
// tb_life_grid_scanner: directed self-checking bench for life_grid_scanner.
//   Drives inputs 1 ns after each rising edge and samples outputs at the same
//   point, i.e. well away from the active edge.
module tb_life_grid_scanner;

  logic        clk;
  logic        rst;
  logic [63:0] grid_flat;
  logic        gen_tick;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_row;
  logic [2:0]  out_row_idx;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] gen_count;
  logic [6:0]  live_count;
  logic        busy;
  logic        overrun;
  logic [7:0]  ovr_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
  localparam logic [63:0] DIAG   = 64'h0102_0408_1020_4080;
  localparam logic [63:0] EDGES  = 64'h8181_8181_8181_8181;
  logic [7:0] glider_rows [8] = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  life_grid_scanner dut (
    .clk         (clk),
    ._rst        (rst),
    .grid_flat   (grid_flat),
    .gen_tick    (gen_tick),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .gen_count   (gen_count),
    .live_count  (live_count),
    .busy        (busy),
    .overrun     (overrun),
    .ovr_count   (ovr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; grid_flat = '0; gen_tick = 1'b0; out_ready = 1'b0;
    #2;
    checks++;
    if ({out_valid, out_row, out_row_idx, out_sof, out_eof, gen_count, live_count,
         busy, overrun, ovr_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b row=%h idx=%0d gen=%0d live=%0d busy=%b ovr=%b ovrc=%0d required all zero",
               out_valid, out_row, out_row_idx, gen_count, live_count, busy, overrun, ovr_count);
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_glider();
    grid_flat = GLIDER; gen_tick = 1'b1; out_ready = 1'b1;
    step();
    gen_tick = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== glider_rows[b] || out_row_idx !== 3'(b) ||
          out_sof !== (b == 0) || out_eof !== (b == 7)) begin
        failures++;
        $display("FAIL glider_beat b=%0d got v=%b row=%h idx=%0d sof=%b eof=%b required v=1 row=%h idx=%0d",
                 b, out_valid, out_row, out_row_idx, out_sof, out_eof, glider_rows[b], b);
      end
      checks++;
      if (gen_count !== 16'd1 || live_count !== 7'd5) begin
        failures++;
        $display("FAIL glider_counts b=%0d got gen=%0d live=%0d required gen=1 live=5", b, gen_count, live_count);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glider_idle got v=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_stall();
    int e = 0;
    grid_flat = GLIDER; gen_tick = 1'b1; out_ready = 1'b0;
    step();
    gen_tick = 1'b0;
    grid_flat = '1;
    for (int cyc = 0; cyc < 60 && e < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      checks++;
      if (out_valid !== 1'b1 || out_row !== glider_rows[e] || out_row_idx !== 3'(e) ||
          out_sof !== (e == 0) || out_eof !== (e == 7) || gen_count !== 16'd2 || live_count !== 7'd5) begin
        failures++;
        $display("FAIL stall_beat cyc=%0d got v=%b row=%h idx=%0d sof=%b eof=%b gen=%0d live=%0d required row=%h idx=%0d gen=2 live=5",
                 cyc, out_valid, out_row, out_row_idx, out_sof, out_eof, gen_count, live_count, glider_rows[e], e);
      end
      step();
      if (out_ready) e++;
    end
    out_ready = 1'b0;
    checks++;
    if (e != 8 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_done got beats=%0d v=%b required beats=8 v=0", e, out_valid);
    end
  endtask

  task automatic test_overrun();
    grid_flat = DIAG; gen_tick = 1'b1; out_ready = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      gen_tick  = (b == 3);
      grid_flat = (b == 3) ? '1 : DIAG;
      checks++;
      if (out_row !== (8'h80 >> b) || out_row_idx !== 3'(b) || gen_count !== 16'd3 || live_count !== 7'd8) begin
        failures++;
        $display("FAIL overrun_beat b=%0d got row=%h idx=%0d gen=%0d live=%0d required row=%h gen=3 live=8",
                 b, out_row, out_row_idx, gen_count, live_count, 8'h80 >> b);
      end
      step();
    end
    gen_tick = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || ovr_count !== 8'd1 || gen_count !== 16'd3) begin
      failures++;
      $display("FAIL overrun_flag got v=%b ovr=%b ovrc=%0d gen=%0d required v=0 ovr=1 ovrc=1 gen=3",
               out_valid, overrun, ovr_count, gen_count);
    end
    // Stall a fresh frame and hammer it with ticks to saturate the counter.
    grid_flat = GLIDER; gen_tick = 1'b1; out_ready = 1'b0;
    step();
    repeat (300) step();
    gen_tick = 1'b0;
    checks++;
    if (ovr_count !== 8'd255 || gen_count !== 16'd4 || out_row_idx !== 3'd0 || out_row !== 8'h02) begin
      failures++;
      $display("FAIL overrun_saturate got ovrc=%0d gen=%0d idx=%0d row=%h required ovrc=255 gen=4 idx=0 row=02",
               ovr_count, gen_count, out_row_idx, out_row);
    end
    out_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (out_valid !== 1'b0 || ovr_count !== 8'd255) begin
      failures++;
      $display("FAIL overrun_drain got v=%b ovrc=%0d required v=0 ovrc=255", out_valid, ovr_count);
    end
  endtask

  task automatic test_back_to_back();
    grid_flat = GLIDER; gen_tick = 1'b1; out_ready = 1'b1;
    step();
    gen_tick = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) begin
        gen_tick = 1'b1; grid_flat = EDGES;
      end
      checks++;
      if (busy !== 1'b1 || out_row !== glider_rows[b] || gen_count !== 16'd5) begin
        failures++;
        $display("FAIL b2b_first b=%0d got busy=%b row=%h gen=%0d required busy=1 row=%h gen=5",
                 b, busy, out_row, gen_count, glider_rows[b]);
      end
      step();
    end
    gen_tick = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_row !== 8'h81 || out_row_idx !== 3'(b) ||
          out_sof !== (b == 0) || gen_count !== 16'd6 || live_count !== 7'd16) begin
        failures++;
        $display("FAIL b2b_second b=%0d got busy=%b v=%b row=%h idx=%0d sof=%b gen=%0d live=%0d required row=81 gen=6 live=16",
                 b, busy, out_valid, out_row, out_row_idx, out_sof, gen_count, live_count);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    grid_flat = GLIDER; gen_tick = 1'b1; out_ready = 1'b1;
    step();
    gen_tick = 1'b0;
    repeat (4) step();
    out_ready = 1'b0;
    checks++;
    if (out_row_idx !== 3'd4 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pos got idx=%0d v=%b required idx=4 v=1", out_row_idx, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got v=%b busy=%b required 0 0", out_valid, busy);
    end
    step(); step();
    #2 rst = 1'b0;
    checks++;
    if (gen_count !== 16'd0 || live_count !== 7'd0 || overrun !== 1'b0 || ovr_count !== 8'd0 || out_row !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_clear got gen=%0d live=%0d ovr=%b ovrc=%0d row=%h required all zero",
               gen_count, live_count, overrun, ovr_count, out_row);
    end
    step();
    gen_tick = 1'b1; out_ready = 1'b1;
    step();
    gen_tick = 1'b0;
    checks++;
    if (gen_count !== 16'd1 || out_row_idx !== 3'd0 || out_row !== 8'h02 || out_sof !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_restart got gen=%0d idx=%0d row=%h sof=%b required gen=1 idx=0 row=02 sof=1",
               gen_count, out_row_idx, out_row, out_sof);
    end
    repeat (8) step();
  endtask

  task automatic test_live_extremes();
    grid_flat = '1; gen_tick = 1'b1; out_ready = 1'b1;
    step();
    gen_tick = 1'b0;
    checks++;
    if (live_count !== 7'd64 || out_row !== 8'hff || gen_count !== 16'd2) begin
      failures++;
      $display("FAIL live_ones got live=%0d row=%h gen=%0d required live=64 row=ff gen=2", live_count, out_row, gen_count);
    end
    repeat (8) step();
    grid_flat = '0; gen_tick = 1'b1;
    step();
    gen_tick = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== 8'h00 || out_row_idx !== 3'(b) || out_eof !== (b == 7) ||
          live_count !== 7'd0 || gen_count !== 16'd3) begin
        failures++;
        $display("FAIL live_zero b=%0d got v=%b row=%h idx=%0d eof=%b live=%0d gen=%0d required v=1 row=00 live=0 gen=3",
                 b, out_valid, out_row, out_row_idx, out_eof, live_count, gen_count);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL live_zero_end got v=%b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_glider();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_live_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
